// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, limits and types for the I2S receive path
package audio_pkg;
   localparam int AUDIO_DW_DEF = 16;
   localparam int MAX_BITS_DEF = 32;
   localparam int TIMEOUT_DEF  = 1024;
   typedef enum logic {SYNC, RUN} rx_state_e;
   typedef logic [AUDIO_DW_DEF-1:0] sample_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer with a third flop forming a rising-edge strobe
module sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise
);
   logic [2:0] sr;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sr <= '0;
      else sr <= {sr[1:0], d};
   assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver delivering left/right PCM pairs with lock and framing-error tracking
module i2s_rx
   import audio_pkg::*;
#(
   parameter int AUDIO_DW = AUDIO_DW_DEF,
   parameter int MAX_BITS = MAX_BITS_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i2s_bck,
   input  logic                i2s_lrck,
   input  logic                i2s_data,
   output logic [AUDIO_DW-1:0] left,
   output logic [AUDIO_DW-1:0] right,
   output logic                sample_valid,
   output logic                locked,
   output logic                frame_err
);
   localparam int CW = $clog2(MAX_BITS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   rx_state_e           state, state_d;
   logic                bck_rise, lrck_s, data_s, lrck_q, word_end;
   logic [1:0]          lrck_sr, data_sr;
   logic [CW-1:0]       cnt;
   logic [TW-1:0]       tcnt;
   logic [AUDIO_DW-1:0] word, word_next, hold_l;
   logic                have_left, overflow, timeout, err, pair;

   sync_edge u_bck (.clk(clk), .reset_n(reset_n), .d(i2s_bck), .rise(bck_rise));

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         lrck_sr <= '0;
         data_sr <= '0;
      end else begin
         lrck_sr <= {lrck_sr[0], i2s_lrck};
         data_sr <= {data_sr[0], i2s_data};
      end

   assign lrck_s   = lrck_sr[1];
   assign data_s   = data_sr[1];
   assign word_end = bck_rise & (lrck_s != lrck_q);

   // current bit folded in, so the LSB arriving on the word_end edge completes the word
   always_comb begin
      word_next = word;
      for (int i = 0; i < AUDIO_DW; i++)
         word_next[i] = (cnt == CW'(AUDIO_DW - 1 - i)) ? data_s : word[i];
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= SYNC;
      else state <= state_d;

   always_comb
      state_d = (state == SYNC) ? (word_end ? RUN : SYNC) : (err ? SYNC : RUN);

   always_comb begin
      overflow = (state == RUN) & bck_rise & ~word_end & (cnt == CW'(MAX_BITS));
      timeout  = (state == RUN) & ~bck_rise & (tcnt == TW'(TIMEOUT - 1));
      err      = overflow | timeout;
      pair     = (state == RUN) & word_end & lrck_q & have_left;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         left         <= '0;
         right        <= '0;
         sample_valid <= 1'b0;
         locked       <= 1'b0;
         frame_err    <= 1'b0;
         lrck_q       <= 1'b0;
         cnt          <= '0;
         tcnt         <= '0;
         word         <= '0;
         hold_l       <= '0;
         have_left    <= 1'b0;
      end else begin
         sample_valid <= pair;
         frame_err    <= err;
         tcnt         <= bck_rise ? '0 : (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + 1'b1;
         if (bck_rise) lrck_q <= lrck_s;
         if (err) begin
            cnt       <= '0;
            word      <= '0;
            have_left <= 1'b0;
            locked    <= 1'b0;
         end else if (state == SYNC) begin
            cnt       <= '0;
            word      <= '0;
            have_left <= 1'b0;
         end else if (word_end) begin
            cnt       <= '0;
            word      <= '0;
            have_left <= ~lrck_q;
            if (!lrck_q) hold_l <= word_next;
            if (pair) begin
               left   <= hold_l;
               right  <= word_next;
               locked <= 1'b1;
            end
         end else if (bck_rise) begin
            word <= word_next;
            cnt  <= cnt + 1'b1;
         end
      end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized I2S stream against a frame-level scoreboard of expected sample pairs
`timescale 1ns/1ps
module tb_i2s_rx;
   localparam int DW = 16;

   logic          clk = 0, reset_n = 1, bck = 0, lrck = 0, data = 0;
   logic [DW-1:0] left, right;
   logic          sample_valid, locked, frame_err;
   int            total = 0, bad = 0, err_cnt = 0, val_cnt = 0, h = 160;
   int            v0, e0;
   int            ws[5] = '{12, 16, 20, 24, 32};
   logic          pend = 0, pv = 0;
   logic [DW-1:0] pl, pr;
   logic [2*DW-1:0] expq[$];
   logic [2*DW-1:0] e_pair;

   always #15.625 clk = ~clk;

   i2s_rx #(.AUDIO_DW(DW)) dut (
      .clk(clk), .reset_n(reset_n), .i2s_bck(bck), .i2s_lrck(lrck), .i2s_data(data),
      .left(left), .right(right), .sample_valid(sample_valid), .locked(locked),
      .frame_err(frame_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // first DW bits of an n-bit MSB-first word, zero padded when n < DW
   function automatic logic [DW-1:0] fit(input logic [31:0] w, input int n);
      logic [63:0] x;
      x = {w, 32'd0} << (32 - n);
      return x[63 -: DW];
   endfunction

   task automatic clks(input int c);
      repeat (c) @(negedge clk);
   endtask

   task automatic bit_out(input logic lr, input logic d);
      bck = 0; lrck = lr; data = d;
      #h;
      bck = 1;
      #h;
   endtask

   // a new left slot completes the previous frame's pair
   task automatic slot(input logic lr, input logic [31:0] w, input int n);
      if (!lr && pv) begin
         expq.push_back({pl, pr});
         pv = 0;
      end
      bit_out(lr, pend);
      for (int k = n - 1; k >= 1; k--) bit_out(lr, w[k]);
      pend = w[0];
   endtask

   task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n, input logic ex);
      slot(0, l, n);
      pl = fit(l, n); pr = fit(r, n); pv = ex;
      slot(1, r, n);
   endtask

   task automatic flush();
      slot(0, 32'd0, 1);
      clks(8);
   endtask

   task automatic rand_frames(input int cnt, input logic first_ex);
      for (int i = 0; i < cnt; i++)
         frame($urandom, $urandom, ws[$urandom_range(0, 4)], first_ex || i > 0);
   endtask

   task automatic do_reset();
      reset_n = 0;
      clks(3);
      pv = 0;
      expq.delete();
      reset_n = 1;
      clks(2);
   endtask

   always @(negedge clk) begin
      if (frame_err) err_cnt++;
      if (sample_valid) begin
         val_cnt++;
         chk("valid_expected", 32'(expq.size() != 0), 1);
         if (expq.size() != 0) begin
            e_pair = expq.pop_front();
            chk("left", left, e_pair[2*DW-1:DW]);
            chk("right", right, e_pair[DW-1:0]);
         end
      end
   end

   initial begin
      h = $urandom_range(70, 170);
      #5 reset_n = 0;
      clks(3);
      chk("rst_left", left, 0);
      chk("rst_right", right, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_err", frame_err, 0);
      reset_n = 1;
      clks(2);

      v0 = val_cnt;
      for (int i = 0; i < 4; i++)
         frame({16'h1234, 16'($urandom)}, {16'hABCD, 16'($urandom)}, 32, i > 0);
      flush();
      chk("t1_valids", val_cnt - v0, 3);
      chk("t1_left", left, 16'h1234);
      chk("t1_right", right, 16'hABCD);
      chk("t1_locked", locked, 1);
      chk("t1_pending", expq.size(), 0);
      chk("t1_err", err_cnt, 0);

      do_reset();
      v0 = val_cnt;
      for (int i = 0; i < 3; i++) frame(32'h8001, 32'h7FFE, 16, i > 0);
      flush();
      chk("t2_valids", val_cnt - v0, 2);
      chk("t2_left", left, 16'h8001);
      chk("t2_right", right, 16'h7FFE);

      do_reset();
      h = $urandom_range(70, 170);
      v0 = val_cnt;
      rand_frames(8, 0);
      flush();
      chk("rnd_valids", val_cnt - v0, 7);
      chk("rnd_pending", expq.size(), 0);
      chk("rnd_locked", locked, 1);

      do_reset();
      e0 = err_cnt;
      rand_frames(3, 0);
      slot(0, $urandom, 33);
      clks(5);
      chk("t3_no_err_at_32", err_cnt - e0, 0);
      chk("t3_locked_before", locked, 1);
      bit_out(0, 1'b1);
      clks(5);
      chk("t3_err_at_33", err_cnt - e0, 1);
      chk("t3_unlocked", locked, 0);
      for (int i = 0; i < 6; i++) bit_out(0, 1'($urandom));
      slot(1, $urandom, 16);
      v0 = val_cnt;
      rand_frames(2, 1);
      flush();
      chk("t3_recover_valids", val_cnt - v0, 2);
      chk("t3_recover_locked", locked, 1);
      chk("t3_pending", expq.size(), 0);
      chk("t3_err_total", err_cnt - e0, 1);

      do_reset();
      rand_frames(3, 0);
      flush();
      e0 = err_cnt;
      clks(1000);
      chk("t4_no_early_err", err_cnt - e0, 0);
      clks(100);
      chk("t4_timeout_err", err_cnt - e0, 1);
      chk("t4_unlocked", locked, 0);
      chk("t4_left_kept", left, pl);
      chk("t4_right_kept", right, pr);

      do_reset();
      v0 = val_cnt;
      slot(1, $urandom, 10);
      clks(4);
      chk("t5_no_valid_partial", val_cnt - v0, 0);
      rand_frames(3, 1);
      flush();
      chk("t5_valids", val_cnt - v0, 3);
      chk("t5_pending", expq.size(), 0);

      do_reset();
      rand_frames(2, 0);
      slot(0, $urandom, 10);
      clks(6);
      chk("t6_pending", expq.size(), 0);
      chk("t6_locked_before", locked, 1);
      @(posedge clk);
      #3 reset_n = 0;
      #3;
      chk("t6_async_left", left, 0);
      chk("t6_async_right", right, 0);
      chk("t6_async_locked", locked, 0);
      clks(2);
      pv = 0;
      expq.delete();
      reset_n = 1;
      clks(2);
      v0 = val_cnt;
      frame($urandom, $urandom, 24, 0);
      frame($urandom, $urandom, 24, 1);
      flush();
      chk("t6_valids", val_cnt - v0, 1);
      chk("t6_pending_end", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
